qspi_xip_ctrl: RTL and testbench
================================

QSPI_XIP_CTRL -- requirements
Module: qspi_xip_ctrl

Interface
REQ-001 SHALL have parameters: AW, 22, word-address width (byte address = {address,2'b00}); DW, 32, data width; SPI_W, 4, flash data lines; DUMMY_CYCLES, 4, SCK cycles between address and data (2..15).
REQ-002 SHALL have ports (clock and reset first):
- aclk in 1: single clock; every flop is on its rising edge.
- aresetn in 1: asynchronous active-low reset.
- address in AW: Avalon-MM word address.
- read in 1: read request.
- write in 1: write request.
- writedata in DW: ignored.
- byteenable in DW/8: ignored.
- waitrequest out 1: request not accepted.
- readdata out DW: read data.
- readdatavalid out 1: readdata valid, one-cycle pulse.
- idle out 1: controller in IDLE.
- SCK out 1: flash clock.
- CSn out 1: flash chip select, active low.
- MISO in SPI_W: flash IO inputs.
- MOSI out SPI_W: flash IO outputs.
- mosi_oe out SPI_W: per-line output enable for the IO buffers.

Function
REQ-003 SHALL use states IDLE, CMD, ADDR, DUMMY, DATA, DONE, CSHI.
REQ-004 SHALL assert waitrequest in every state except IDLE; idle=1 only in IDLE.
REQ-005 In IDLE with read=1, the request SHALL be accepted on that edge: latch address, go to CMD.
- A write with read=0 is accepted and discarded, no readdatavalid.
- read=1 with write=1: the read wins and the write is discarded.
REQ-006 Each SCK bit SHALL take 2 aclk cycles.
- Phase 0: SCK=0, MOSI/mosi_oe updated.
- Phase 1: SCK=1; MISO sampled on the aclk edge ending phase 1.
REQ-007 CMD SHALL shift 8'hEB MSB-first on MOSI[0] for 8 SCK, with mosi_oe=4'b0001.
REQ-008 ADDR SHALL shift the 24-bit byte address MSB-nibble-first on MOSI[3:0] for 6 SCK, with mosi_oe=4'hF.
- Address bits above the AW+2 supplied bits are zero.
REQ-009 DUMMY SHALL last DUMMY_CYCLES SCK.
- First 2 SCK: drive mode nibbles 4'h0 with oe=4'hF.
- Remainder: oe=4'h0, MOSI=0.
REQ-010 DATA SHALL sample 8 nibbles, with oe=4'h0.
- Nibble k (k=0..7) goes to readdata[8*(k/2)+4*(1-k%2) +: 4], i.e. first byte to [7:0], high nibble first.
REQ-011 CSn SHALL be 0 from the first CMD cycle through the last DATA cycle, and 1 otherwise.
REQ-012 DONE SHALL last 1 cycle: readdatavalid=1, readdata stable, CSn=1, SCK=0.
REQ-013 CSHI SHALL hold CSn=1 for 4 cycles, then return to IDLE.
REQ-014 Latency from the acceptance edge to readdatavalid SHALL be 2*(22+DUMMY_CYCLES)+1 cycles (53 for DUMMY_CYCLES=4).
REQ-015 Acceptance-to-acceptance period SHALL be 2*(22+DUMMY_CYCLES)+6 cycles for back-to-back reads.
REQ-016 readdata SHALL hold its last value until the next DONE.
REQ-017 A single bit counter (6 bits) and phase flop SHALL sequence all states; counter wrap SHALL never occur.
REQ-018 Only one read SHALL be outstanding; requests arriving while busy stall on waitrequest.

Reset
REQ-019 On aresetn=0, asynchronously:
- state=IDLE, CSn=1, SCK=0, MOSI=0, mosi_oe=0.
- readdatavalid=0, readdata=0, waitrequest=1, idle=0.
REQ-020 While aresetn=0, waitrequest SHALL be 1.
REQ-021 After release, the block SHALL go to IDLE on the first aclk edge (waitrequest=0, idle=1).
REQ-022 Reset mid-transaction SHALL abort it: CSn=1 immediately, and no readdatavalid for the aborted read.

Structure
REQ-023 qspi_pkg SHALL hold the state enum, CMD_QUAD_IO_READ=8'hEB, MODE_NIBBLE=4'h0, CMD_BITS=8, ADDR_SCK=6, DATA_SCK=8, CS_HIGH_CYC=4.
REQ-024 SHALL instantiate one sub-module, qspi_shreg: a loadable shift register with 1-bit/4-bit shift modes, used for both the outgoing command/address and the incoming data.

Verification (flash BFM on MISO/MOSI, DUMMY_CYCLES=4)
REQ-025 read @address=22'h000001, flash bytes 0x04..0x07 = 11 22 33 44 -> MOSI[0] carries 0xEB, MOSI carries address 24'h000004, readdata=32'h44332211 exactly 53 cycles after acceptance.
REQ-026 Two back-to-back reads -> second accepted 58 cycles after first; CSn high at least 4 cycles between them.
REQ-027 write=1 in IDLE -> accepted in 1 cycle, CSn stays 1, no readdatavalid.
REQ-028 read=1 and write=1 in the same cycle -> exactly one readdatavalid, no extra cycles.
REQ-029 aresetn pulsed low at cycle 30 of a read -> CSn=1 within the same cycle, no readdatavalid, next read completes correctly.
REQ-030 mosi_oe checked every cycle -> 0x1 in CMD, 0xF in ADDR and first 2 dummy SCK, 0x0 otherwise.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI execute-in-place controller.
// Holds the controller state encoding and the fixed flash-protocol sizes.
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        DONE,
        CSHI
    } state_e;

    localparam logic [7:0] CMD_QUAD_IO_READ = 8'hEB;
    localparam logic [3:0] MODE_NIBBLE      = 4'h0;

    localparam int CMD_BITS    = 8;
    localparam int ADDR_SCK    = 6;
    localparam int DATA_SCK    = 8;
    localparam int CS_HIGH_CYC = 4;
    localparam int MODE_SCK    = 2;

    // Flash returns bytes in ascending address order; the bus is little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/qspi_shreg.sv
// Loadable left-shift register, 1-bit or 4-bit per shift.
// MSB feeds the flash IO lines; the LSB end collects sampled IO nibbles.
module qspi_shreg #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         quad,
    input  logic [3:0]   sin,
    output logic [W-1:0] q
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Load has priority; otherwise shift one bit or one nibble.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_val;
        end else if (shift) begin
            sr_d = quad ? {sr_q[W-5:0], sin} : {sr_q[W-2:0], sin[0]};
        end
    end

    // Shift register state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/qspi_xip_ctrl.sv
// Avalon-MM read port mapped onto a quad-IO (0xEB) flash read.
// One read in flight; each SCK bit spans two aclk cycles.
module qspi_xip_ctrl
    import qspi_pkg::*;
#(
    parameter int AW           = 22,
    parameter int DW           = 32,
    parameter int SPI_W        = 4,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [AW-1:0]     address,
    input  logic              read,
    input  logic              write,
    input  logic [DW-1:0]     writedata,
    input  logic [DW/8-1:0]   byteenable,
    output logic              waitrequest,
    output logic [DW-1:0]     readdata,
    output logic              readdatavalid,
    output logic              idle,
    output logic              SCK,
    output logic              CSn,
    input  logic [SPI_W-1:0]  MISO,
    output logic [SPI_W-1:0]  MOSI,
    output logic [SPI_W-1:0]  mosi_oe
);

    state_e        state_q, state_d;
    state_e        seg_next;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    seg_last;
    logic          phase_q, phase_d;
    logic          rdy_q, rdy_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          sr_load;
    logic          sr_shift;
    logic          sr_quad;
    logic [31:0]   sr_q;
    logic [23:0]   byte_addr;

    // Writes are acknowledged and dropped, so their payload is never looked at.
    logic unused_ok;
    assign unused_ok = ^{write, writedata, byteenable};

    assign byte_addr = 24'({address, 2'b00});
    assign sr_quad   = (state_q != CMD);

    qspi_shreg #(.W(32)) u_shreg (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (sr_load),
        .load_val ({CMD_QUAD_IO_READ, byte_addr}),
        .shift    (sr_shift),
        .quad     (sr_quad),
        .sin      (MISO),
        .q        (sr_q)
    );

    // State, bit counter, SCK phase, ready and captured read data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
        end
    end

    // Length and successor of each SCK-driven segment.
    always_comb begin
        seg_last = 6'(CMD_BITS - 1);
        seg_next = ADDR;
        unique case (state_q)
            ADDR: begin
                seg_last = 6'(ADDR_SCK - 1);
                seg_next = DUMMY;
            end
            DUMMY: begin
                seg_last = 6'(DUMMY_CYCLES - 1);
                seg_next = DATA;
            end
            DATA: begin
                seg_last = 6'(DATA_SCK - 1);
                seg_next = DONE;
            end
            default: ;
        endcase
    end

    // Next state: bits advance on the edge that ends the SCK-high phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        rdy_d    = 1'b1;
        rdata_d  = rdata_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rdy_q && read) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    sr_load = 1'b1;
                end
            end
            CMD, ADDR, DUMMY, DATA: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    sr_shift = (state_q != DUMMY);
                    if (cnt_q == seg_last) begin
                        cnt_d   = '0;
                        state_d = seg_next;
                        if (state_q == DATA) begin
                            rdata_d = DW'(bswap32({sr_q[27:0], MISO}));
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = CSHI;
                cnt_d   = '0;
            end
            CSHI: begin
                if (cnt_q == 6'(CS_HIGH_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flash pins and bus handshake decoded from the current state.
    always_comb begin
        CSn     = 1'b1;
        SCK     = 1'b0;
        MOSI    = '0;
        mosi_oe = '0;
        unique case (state_q)
            CMD: begin
                CSn     = 1'b0;
                SCK     = phase_q;
                MOSI    = {{(SPI_W-1){1'b0}}, sr_q[31]};
                mosi_oe = {{(SPI_W-1){1'b0}}, 1'b1};
            end
            ADDR: begin
                CSn     = 1'b0;
                SCK     = phase_q;
                MOSI    = sr_q[31:28];
                mosi_oe = '1;
            end
            DUMMY: begin
                CSn = 1'b0;
                SCK = phase_q;
                if (cnt_q < 6'(MODE_SCK)) begin
                    MOSI    = MODE_NIBBLE;
                    mosi_oe = '1;
                end
            end
            DATA: begin
                CSn = 1'b0;
                SCK = phase_q;
            end
            default: ;
        endcase
    end

    assign idle          = (state_q == IDLE) && rdy_q;
    assign waitrequest   = !idle;
    assign readdatavalid = (state_q == DONE);
    assign readdata      = rdata_q;

endmodule

// File: tb/tb_qspi_xip_ctrl.sv
// Bench for qspi_xip_ctrl: flash model on the IO lines plus a
// transaction-level reference checked on every aclk cycle.
module tb_qspi_xip_ctrl;

    localparam int AW   = 22;
    localparam int DW   = 32;
    localparam int NSCK = 8 + 6 + 4 + 8;
    localparam int LAT  = 2 * NSCK + 1;
    localparam int PER  = 2 * NSCK + 6;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] writedata = '0;
    logic [3:0]    byteenable = '0;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          idle;
    logic          SCK;
    logic          CSn;
    logic [3:0]    MISO = 4'h0;
    logic [3:0]    MOSI;
    logic [3:0]    mosi_oe;

    qspi_xip_ctrl #(
        .AW(AW), .DW(DW), .SPI_W(4), .DUMMY_CYCLES(4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .idle          (idle),
        .SCK           (SCK),
        .CSn           (CSn),
        .MISO          (MISO),
        .MOSI          (MOSI),
        .mosi_oe       (mosi_oe)
    );

    always #5 aclk = ~aclk;

    logic [7:0]  mem [256];
    logic [7:0]  cmd_byte = 8'hEB;
    int          cyc = 0;
    logic        alive = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          acc = 0;
    int          acc_cnt = 0;
    int          rd_cnt = 0;
    int          tmo_req = 0;
    int          tmo_seen = 0;
    logic        busy = 1'b0;
    logic        b2b = 1'b0;
    logic [23:0] e_baddr = '0;
    logic [31:0] e_data = '0;
    logic [31:0] last_rd = '0;
    logic [7:0]  bfm_cmd = '0;
    logic [23:0] bfm_addr = '0;
    int          nr = 0;

    function automatic logic [7:0] fb(input logic [23:0] a);
        return mem[a[7:0]] ^ a[15:8] ^ a[23:16];
    endfunction

    function automatic logic [3:0] nib(input int d);
        logic [7:0] b;
        b = fb(bfm_addr + 24'(d / 2));
        return (d % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, got, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;
    always @(posedge aclk) alive <= aresetn;

    // Flash model: decodes command/address from MOSI, serves data nibbles.
    always @(negedge aclk) begin : bfm
        if (CSn) begin
            nr = 0;
            MISO = 4'h0;
        end else if (SCK) begin
            if (nr < 8) bfm_cmd = {bfm_cmd[6:0], MOSI[0]};
            else if (nr < 14) bfm_addr = {bfm_addr[19:0], MOSI};
            nr++;
        end else if (nr >= 18 && nr < 26) begin
            MISO = nib(nr - 18);
        end else begin
            MISO = 4'hA;
        end
    end

    // Reference model and per-cycle comparison.
    always @(negedge aclk) begin : cmp
        int j;
        int k;
        logic ew, ei, ec, es, er;
        logic [3:0] eo, em;
        chk("timeout", 32'(tmo_req), 32'(tmo_seen));
        tmo_seen = tmo_req;
        if (!aresetn) begin
            busy = 1'b0;
            last_rd = '0;
            chk("rst_waitreq", 32'(waitrequest), 32'd1);
            chk("rst_idle", 32'(idle), 32'd0);
            chk("rst_csn", 32'(CSn), 32'd1);
            chk("rst_sck", 32'(SCK), 32'd0);
            chk("rst_oe", 32'(mosi_oe), 32'd0);
            chk("rst_mosi", 32'(MOSI), 32'd0);
            chk("rst_rdv", 32'(readdatavalid), 32'd0);
            chk("rst_rdata", readdata, 32'd0);
        end else begin
            if (busy && (cyc - acc) >= PER - 1) busy = 1'b0;
            ew = !alive; ei = alive; ec = 1'b1; es = 1'b0; er = 1'b0;
            eo = 4'h0; em = 4'h0;
            if (busy) begin
                j = cyc - acc;
                ew = 1'b1;
                ei = 1'b0;
                if (j < 2 * NSCK) begin
                    ec = 1'b0;
                    es = j[0];
                    k = j / 2;
                    if (k < 8) begin
                        eo = 4'h1;
                        em = {3'b000, cmd_byte[7-k]};
                    end else if (k < 14) begin
                        eo = 4'hF;
                        em = e_baddr[4*(13-k) +: 4];
                    end else if (k < 16) begin
                        eo = 4'hF;
                    end
                end else if (j == LAT - 1) begin
                    er = 1'b1;
                    last_rd = e_data;
                end
            end
            chk("waitrequest", 32'(waitrequest), 32'(ew));
            chk("idle", 32'(idle), 32'(ei));
            chk("csn", 32'(CSn), 32'(ec));
            chk("sck", 32'(SCK), 32'(es));
            chk("mosi_oe", 32'(mosi_oe), 32'(eo));
            chk("mosi", 32'(MOSI), 32'(em));
            chk("rdv", 32'(readdatavalid), 32'(er));
            chk("readdata", readdata, last_rd);
            if (readdatavalid && busy) begin
                chk("latency53", 32'(cyc + 1 - acc), 32'd53);
                if (rd_cnt == 0) begin
                    chk("pin_rdata", readdata, 32'h44332211);
                    chk("pin_cmd", 32'(bfm_cmd), 32'hEB);
                    chk("pin_addr", 32'(bfm_addr), 32'h000004);
                end
                rd_cnt++;
            end
            if (read && !waitrequest) begin
                if (b2b) chk("period58", 32'(cyc + 1 - acc), 32'd58);
                acc = cyc + 1;
                busy = 1'b1;
                e_baddr = 24'({address, 2'b00});
                e_data = {fb(e_baddr + 24'd3), fb(e_baddr + 24'd2),
                          fb(e_baddr + 24'd1), fb(e_baddr)};
                acc_cnt++;
            end
        end
    end

    task automatic accept_wait();
        int n0;
        n0 = acc_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            #1;
            if (acc_cnt != n0) return;
        end
        tmo_req++;
    endtask

    task automatic wait_done();
        int n0;
        n0 = rd_cnt;
        for (int i = 0; i < 120; i++) begin
            @(negedge aclk);
            #1;
            if (rd_cnt != n0) return;
        end
        tmo_req++;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic w);
        @(posedge aclk);
        #1;
        address = a;
        read = 1'b1;
        write = w;
        accept_wait();
        @(posedge aclk);
        #1;
        read = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 29 + 7);
        mem[4] = 8'h11;
        mem[5] = 8'h22;
        mem[6] = 8'h33;
        mem[7] = 8'h44;
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b1;
        repeat (4) @(posedge aclk);

        do_read(22'h000001, 1'b0);
        wait_done();

        @(posedge aclk);
        #1;
        address = 22'h000040;
        read = 1'b1;
        accept_wait();
        b2b = 1'b1;
        @(posedge aclk);
        #1;
        address = 22'h13579B;
        accept_wait();
        @(posedge aclk);
        #1;
        read = 1'b0;
        b2b = 1'b0;
        wait_done();

        @(posedge aclk);
        #1;
        write = 1'b1;
        writedata = 32'hDEADBEEF;
        byteenable = 4'hF;
        @(posedge aclk);
        #1;
        write = 1'b0;
        repeat (5) @(posedge aclk);

        do_read(22'h0000A5, 1'b1);
        wait_done();
        repeat (3) @(posedge aclk);

        do_read(22'h000010, 1'b0);
        repeat (29) @(posedge aclk);
        #3 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b1;
        repeat (3) @(posedge aclk);

        do_read(22'h2ABCDE, 1'b0);
        wait_done();
        repeat (8) @(posedge aclk);
        @(negedge aclk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
